aes_block_loader: RTL and testbench

//  Front-end stage ahead of cipher ROUND=1. Assembles a 128-bit key and a
//  128-bit plaintext block from a word-serial valid/ready bus. Performs the

---
 rtl/aes_block_loader_pkg.sv | 24 ++
 rtl/aes_block_loader_if.sv | 29 ++
 rtl/aes_word_assembler.sv | 60 ++++++
 rtl/aes_block_loader.sv | 120 ++++++++++++
 tb/tb_aes_block_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_block_loader_pkg.sv
// Shared types for the AES block loader: block width, loader FSM states and
// the ready pattern each state presents to the word source.
package aes_block_loader_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef logic [AES_BLOCK_W-1:0] block;

   typedef enum logic [1:0] {
      LOAD,
      WAIT_KEY,
      EMIT
   } loader_state_e;

   // Returns {dataReady, keyReady} for the state being entered.
   function automatic logic [1:0] readiesFor(input loader_state_e s);
      case (s)
         LOAD:     return 2'b11;
         WAIT_KEY: return 2'b01;
         default:  return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Word-serial valid/ready bus feeding the AES block loader.
// The master is the word source; the slave is the loader.
interface aes_block_loader_if #(
   parameter int WORD_W = 32
) ();

   logic              i_valid;
   logic              i_key_sel;
   logic [WORD_W-1:0] i_word;
   logic              o_data_ready;
   logic              o_key_ready;

   modport master (
      output i_valid,
      output i_key_sel,
      output i_word,
      input  o_data_ready,
      input  o_key_ready
   );

   modport slave (
      input  i_valid,
      input  i_key_sel,
      input  i_word,
      output o_data_ready,
      output o_key_ready
   );

endinterface

// File: rtl/aes_word_assembler.sv
// Collects NWORDS words (MSW first) into a 128-bit register; o_full is set
// by the final word and cleared again when a new word 0 arrives.
module aes_word_assembler
   import aes_block_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic              i_clearCount,
   input  logic              i_clearValue,
   output logic              o_full,
   output logic              o_lastAccept,
   output block              o_value
);

   localparam int NWORDS = AES_BLOCK_W / WORD_W;
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   logic [CW-1:0] r_count;
   logic          r_full;
   block          r_value;

   assign o_lastAccept = i_load && (r_count == CW'(NWORDS - 1));
   assign o_full       = r_full;
   assign o_value      = r_value;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_full  <= 1'b0;
         r_value <= '0;
      end else begin
         if (i_clearCount) begin
            r_count <= '0;
         end else if (i_load) begin
            r_count <= o_lastAccept ? '0 : r_count + CW'(1);
         end
         if (i_clearValue) begin
            r_value <= '0;
            r_full  <= 1'b0;
         end else if (i_load) begin
            for (int s = 0; s < NWORDS; s++) begin
               if (r_count == CW'(s)) begin
                  r_value[AES_BLOCK_W-1-s*WORD_W -: WORD_W] <= i_word;
               end
            end
            // A fresh word 0 means the old contents are being replaced.
            if (o_lastAccept) begin
               r_full <= 1'b1;
            end else if (r_count == '0) begin
               r_full <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// Loads key and plaintext word-serially, applies AddRoundKey (round 0) and
// launches round 1. Define AES_KEY_ZEROIZE_EN to wipe the key after each launch.
module aes_block_loader
   import aes_block_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   aes_block_loader_if.slave   bus,
   output logic                o_key_valid,
   output logic                o_tx_en,
   output block                o_state,
   output block                o_round_key
);

   loader_state_e r_fsm;
   logic          r_dataReady;
   logic          r_keyReady;
   logic          r_txEn;
   block          r_state;
   block          r_roundKey;

   logic w_keyAccept;
   logic w_dataAccept;
   logic w_keyFull;
   logic w_keyLast;
   logic w_dataLast;
   logic w_unusedDataFull;
   logic w_launch;
   logic w_zeroize;
   block w_keyValue;
   block w_dataValue;

   assign w_keyAccept  = bus.i_valid &  bus.i_key_sel & r_keyReady;
   assign w_dataAccept = bus.i_valid & ~bus.i_key_sel & r_dataReady;
   assign w_launch     = (r_fsm == EMIT);

`ifdef AES_KEY_ZEROIZE_EN
   assign w_zeroize = w_launch;
`else
   assign w_zeroize = 1'b0;
`endif

   aes_word_assembler #(.WORD_W(WORD_W)) u_keyAsm (
      .clock        (clock),
      .reset        (reset),
      .i_load       (w_keyAccept),
      .i_word       (bus.i_word),
      .i_clearCount (w_zeroize),
      .i_clearValue (w_zeroize),
      .o_full       (w_keyFull),
      .o_lastAccept (w_keyLast),
      .o_value      (w_keyValue)
   );

   aes_word_assembler #(.WORD_W(WORD_W)) u_dataAsm (
      .clock        (clock),
      .reset        (reset),
      .i_load       (w_dataAccept),
      .i_word       (bus.i_word),
      .i_clearCount (w_launch),
      .i_clearValue (1'b0),
      .o_full       (w_unusedDataFull),
      .o_lastAccept (w_dataLast),
      .o_value      (w_dataValue)
   );

   assign bus.o_data_ready = r_dataReady;
   assign bus.o_key_ready  = r_keyReady;
   assign o_key_valid      = w_keyFull;
   assign o_tx_en          = r_txEn;
   assign o_state          = r_state;
   assign o_round_key      = r_roundKey;

   // Readies are registered alongside the state so the source sees them
   // change exactly at the edge the FSM moves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fsm                      <= LOAD;
         {r_dataReady, r_keyReady}  <= readiesFor(LOAD);
         r_txEn                     <= 1'b0;
         r_state                    <= '0;
         r_roundKey                 <= '0;
      end else begin
         r_txEn <= 1'b0;
         case (r_fsm)
            LOAD: begin
               if (w_dataLast) begin
                  if (w_keyFull) begin
                     r_fsm                     <= EMIT;
                     {r_dataReady, r_keyReady} <= readiesFor(EMIT);
                  end else begin
                     r_fsm                     <= WAIT_KEY;
                     {r_dataReady, r_keyReady} <= readiesFor(WAIT_KEY);
                  end
               end
            end
            WAIT_KEY: begin
               if (w_keyLast) begin
                  r_fsm                     <= EMIT;
                  {r_dataReady, r_keyReady} <= readiesFor(EMIT);
               end
            end
            EMIT: begin
               r_txEn                    <= 1'b1;
               r_state                   <= w_dataValue ^ w_keyValue;
               r_roundKey                <= w_keyValue;
               r_fsm                     <= LOAD;
               {r_dataReady, r_keyReady} <= readiesFor(LOAD);
            end
            default: begin
               r_fsm                     <= LOAD;
               {r_dataReady, r_keyReady} <= readiesFor(LOAD);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: directed FIPS-197 vectors at WORD_W=32
// plus gapped random traffic at WORD_W=8 and 64 checked by a monitor per DUT.
module tb_aes_block_loader;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] ST  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P3  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] ONES = {128{1'b1}};

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   aes_block_loader_if #(.WORD_W(32)) bus32 ();
   aes_block_loader_if #(.WORD_W(8))  bus8 ();
   aes_block_loader_if #(.WORD_W(64)) bus64 ();

   logic         keyValid32, txEn32, keyValid8, txEn8, keyValid64, txEn64;
   logic [127:0] state32, roundKey32, state8, roundKey8, state64, roundKey64;

   aes_block_loader #(.WORD_W(32)) dut32 (
      .clock(clock), .reset(reset), .bus(bus32), .o_key_valid(keyValid32),
      .o_tx_en(txEn32), .o_state(state32), .o_round_key(roundKey32));
   aes_block_loader #(.WORD_W(8)) dut8 (
      .clock(clock), .reset(reset), .bus(bus8), .o_key_valid(keyValid8),
      .o_tx_en(txEn8), .o_state(state8), .o_round_key(roundKey8));
   aes_block_loader #(.WORD_W(64)) dut64 (
      .clock(clock), .reset(reset), .bus(bus64), .o_key_valid(keyValid64),
      .o_tx_en(txEn64), .o_state(state64), .o_round_key(roundKey64));

   logic [255:0] exp32[$];
   logic [255:0] exp8[$];
   logic [255:0] exp64[$];
   int           launchCyc32[$];
   logic         prevTx32 = 1'b0;
   logic         prevTx8  = 1'b0;
   logic         prevTx64 = 1'b0;

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic reportSpurious(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s launch with empty scoreboard actual=1 expected=0", name);
   endtask

   // One monitor per DUT: every launch pops the oldest expectation.
   always @(negedge clock) begin
      if (!reset && txEn32) begin
         checkOutput("txDouble32", prevTx32, 1'b0);
         launchCyc32.push_back(cycle);
         if (exp32.size() == 0) reportSpurious("spurious32");
         else checkOutput("launch32", {state32, roundKey32}, exp32.pop_front());
      end
      prevTx32 = txEn32;
   end

   always @(negedge clock) begin
      if (!reset && txEn8) begin
         checkOutput("txDouble8", prevTx8, 1'b0);
         if (exp8.size() == 0) reportSpurious("spurious8");
         else checkOutput("launch8", {state8, roundKey8}, exp8.pop_front());
      end
      prevTx8 = txEn8;
   end

   always @(negedge clock) begin
      if (!reset && txEn64) begin
         checkOutput("txDouble64", prevTx64, 1'b0);
         if (exp64.size() == 0) reportSpurious("spurious64");
         else checkOutput("launch64", {state64, roundKey64}, exp64.pop_front());
      end
      prevTx64 = txEn64;
   end

   task automatic applyStimulus(input logic keySel, input logic [31:0] word);
      int waitCycles = 0;
      bus32.i_valid   = 1'b1;
      bus32.i_key_sel = keySel;
      bus32.i_word    = word;
      while (!(keySel ? bus32.o_key_ready : bus32.o_data_ready) && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      if (waitCycles >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout32 actual=0 expected=1");
      end
      @(posedge clock); #1;
      bus32.i_valid = 1'b0;
   endtask

   task automatic sendBlock32(input logic keySel, input logic [127:0] blk,
                              input int first, input int last);
      for (int i = first; i <= last; i++) applyStimulus(keySel, blk[127-32*i -: 32]);
   endtask

   task automatic sendWord8(input logic keySel, input logic [7:0] word);
      int waitCycles = 0;
      int gap = $urandom_range(0, 1);
      repeat (gap) begin @(posedge clock); #1; end
      bus8.i_valid   = 1'b1;
      bus8.i_key_sel = keySel;
      bus8.i_word    = word;
      while (!(keySel ? bus8.o_key_ready : bus8.o_data_ready) && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      if (waitCycles >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout8 actual=0 expected=1");
      end
      @(posedge clock); #1;
      bus8.i_valid = 1'b0;
   endtask

   task automatic sendWord64(input logic keySel, input logic [63:0] word);
      int waitCycles = 0;
      int gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clock); #1; end
      bus64.i_valid   = 1'b1;
      bus64.i_key_sel = keySel;
      bus64.i_word    = word;
      while (!(keySel ? bus64.o_key_ready : bus64.o_data_ready) && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      if (waitCycles >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout64 actual=0 expected=1");
      end
      @(posedge clock); #1;
      bus64.i_valid = 1'b0;
   endtask

   task automatic randomBlocks8(input int n);
      logic [127:0] key, pt;
      for (int b = 0; b < n; b++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         exp8.push_back({pt ^ key, key});
         for (int i = 0; i < 16; i++) sendWord8(1'b1, key[127-8*i -: 8]);
         for (int i = 0; i < 16; i++) sendWord8(1'b0, pt[127-8*i -: 8]);
      end
   endtask

   task automatic randomBlocks64(input int n);
      logic [127:0] key, pt;
      for (int b = 0; b < n; b++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         exp64.push_back({pt ^ key, key});
         for (int i = 0; i < 2; i++) sendWord64(1'b1, key[127-64*i -: 64]);
         for (int i = 0; i < 2; i++) sendWord64(1'b0, pt[127-64*i -: 64]);
      end
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_txEn"},      txEn32,             1'b0);
      checkOutput({tag, "_state"},     state32,            128'd0);
      checkOutput({tag, "_roundKey"},  roundKey32,         128'd0);
      checkOutput({tag, "_keyValid"},  keyValid32,         1'b0);
      checkOutput({tag, "_dataReady"}, bus32.o_data_ready, 1'b1);
      checkOutput({tag, "_keyReady"},  bus32.o_key_ready,  1'b1);
   endtask

   initial begin
      bus32.i_valid = 1'b0; bus32.i_key_sel = 1'b0; bus32.i_word = '0;
      bus8.i_valid  = 1'b0; bus8.i_key_sel  = 1'b0; bus8.i_word  = '0;
      bus64.i_valid = 1'b0; bus64.i_key_sel = 1'b0; bus64.i_word = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      checkResetState("reset");

      // FIPS-197 vector, key first.
      sendBlock32(1'b1, KEY, 0, 3);
      checkOutput("keyValidLoaded", keyValid32, 1'b1);
      sendBlock32(1'b0, PT, 0, 2);
      exp32.push_back({ST, KEY});
      sendBlock32(1'b0, PT, 3, 3);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("stateHeld", state32, ST);

      // Plaintext before key parks in WAIT_KEY.
      pulseReset();
      sendBlock32(1'b0, PT, 0, 3);
      checkOutput("waitKeyDataReady", bus32.o_data_ready, 1'b0);
      checkOutput("waitKeyKeyReady",  bus32.o_key_ready,  1'b1);
      sendBlock32(1'b1, KEY, 0, 2);
      exp32.push_back({ST, KEY});
      sendBlock32(1'b1, KEY, 3, 3);

      // Zero plaintext straight after the launch.
`ifdef AES_KEY_ZEROIZE_EN
      sendBlock32(1'b0, 128'd0, 0, 3);
      checkOutput("zeroizeDataReady", bus32.o_data_ready, 1'b0);
      checkOutput("zeroizeKeyValid",  keyValid32,         1'b0);
      sendBlock32(1'b1, KEY, 0, 2);
      exp32.push_back({KEY, KEY});
      sendBlock32(1'b1, KEY, 3, 3);
      repeat (4) @(posedge clock);
      #1;
`else
      sendBlock32(1'b0, 128'd0, 0, 2);
      exp32.push_back({KEY, KEY});
      sendBlock32(1'b0, 128'd0, 3, 3);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("launchSpacing",
                  launchCyc32[launchCyc32.size()-1] - launchCyc32[launchCyc32.size()-2], 5);
`endif

      // Reset mid-load discards the partial plaintext.
      sendBlock32(1'b0, ONES, 0, 1);
      pulseReset();
      checkResetState("midReset");
      sendBlock32(1'b1, KEY, 0, 3);
      exp32.push_back({P2 ^ KEY, KEY});
      sendBlock32(1'b0, P2, 0, 3);
      repeat (4) @(posedge clock);
      #1;
      checkOutput("freshBlockState", state32, P2 ^ KEY);

      // Key rewrite while plaintext is half loaded.
      sendBlock32(1'b0, P3, 0, 1);
      sendBlock32(1'b1, K2, 0, 0);
      checkOutput("rewriteKeyValid0", keyValid32, 1'b0);
      sendBlock32(1'b1, K2, 1, 2);
      checkOutput("rewriteKeyValid2", keyValid32, 1'b0);
      checkOutput("rewriteDataReady", bus32.o_data_ready, 1'b1);
      sendBlock32(1'b1, K2, 3, 3);
      checkOutput("rewriteKeyValid3", keyValid32, 1'b1);
      exp32.push_back({P3 ^ K2, K2});
      sendBlock32(1'b0, P3, 2, 3);
      repeat (4) @(posedge clock);
      #1;

      fork
         randomBlocks8(300);
         randomBlocks64(1000);
      join
      repeat (6) @(posedge clock);
      #1;

      checkOutput("pending32", exp32.size(), 0);
      checkOutput("pending8",  exp8.size(),  0);
      checkOutput("pending64", exp64.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      checks++;
      errors++;
      $display("[TB] FAIL watchdog actual=timeout expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
